fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_perf_counters.sv | 30 +++
 rtl/fetch_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the interface, the stage and its perf-counter sub-block.
package fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  function automatic logic [PC_W-1:0] sat_inc(
    input logic [PC_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port between the fetch stage and imem.
// master = fetch stage, slave = memory.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating fetch / stall event counters for the fetch stage.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_fetch,
  input  logic            i_stall,
  output logic [PC_W-1:0] o_fetch_cnt,
  output logic [PC_W-1:0] o_stall_cnt
);

  logic [PC_W-1:0] r_fetch_cnt;
  logic [PC_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch) r_fetch_cnt <= sat_inc(r_fetch_cnt);
      if (i_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: imem request FSM, one-entry hold buffer, IF/ID register.
// Define FETCH_PERF_CNT_EN to build the performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              INSTR_W = 16,
  parameter logic [PC_W-1:0] PC_STEP = 16'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               flush_in,
  input  logic               stall_in,
  fetch_if.master            imem,
  output logic [PC_W-1:0]    next_pc,
  output logic               pc_nop,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    perf_fetch_cnt,
  output logic [PC_W-1:0]    perf_stall_cnt
);

  state_t             r_state;
  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_hold_pc;
  logic [INSTR_W-1:0] r_hold_instr;

  logic w_ready;
  logic w_idle;
  logic w_take;
  logic w_park;
  logic w_bubble;
  logic w_release;
  logic w_nop;

  assign w_ready = imem.imem_ready;

  // Flush is folded in here so none of these fire in a flush cycle.
  assign w_idle    = !flush_in && r_state == IDLE;
  assign w_take    = !flush_in && r_state == REQ
                     && w_ready && !stall_in;
  assign w_park    = !flush_in && r_state == REQ
                     && w_ready && stall_in;
  assign w_bubble  = !flush_in && r_state == REQ
                     && !w_ready && !stall_in;
  assign w_release = !flush_in && r_state == HOLD
                     && !stall_in;

  always_comb begin
    next_pc = flush_in ? branch_target : pc_in + PC_STEP;
  end

  always_comb begin
    w_nop = 1'b1;
    if (reset)
      w_nop = 1'b1;
    else if (flush_in)
      w_nop = 1'b0;
    else
      w_nop = !(w_take || w_release);
  end

  assign pc_nop         = w_nop;
  assign imem.imem_req  = !reset && r_state == REQ;
  assign imem.imem_addr = pc_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_pc         <= RESET_VEC;
      r_instr      <= '0;
      r_hold_pc    <= RESET_VEC;
      r_hold_instr <= '0;
    end else if (flush_in) begin
      r_state      <= REQ;
      r_valid      <= 1'b0;
      r_hold_pc    <= RESET_VEC;
      r_hold_instr <= '0;
    end else begin
      unique case (1'b1)
        w_idle: r_state <= REQ;
        w_take: begin
          r_valid <= 1'b1;
          r_pc    <= pc_in;
          r_instr <= imem.imem_rdata;
        end
        w_park: begin
          r_hold_pc    <= pc_in;
          r_hold_instr <= imem.imem_rdata;
          r_state      <= HOLD;
        end
        w_bubble: r_valid <= 1'b0;
        w_release: begin
          r_valid <= 1'b1;
          r_pc    <= r_hold_pc;
          r_instr <= r_hold_instr;
          r_state <= REQ;
        end
        default: ;
      endcase
    end
  end

  assign if_id_valid = r_valid;
  assign if_id_pc    = r_pc;
  assign if_id_instr = r_instr;

`ifdef FETCH_PERF_CNT_EN
  logic w_load;
  logic w_stall_evt;

  assign w_load      = w_take || w_release;
  assign w_stall_evt = w_nop && !flush_in;

  fetch_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_fetch     (w_load),
    .i_stall     (w_stall_evt),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_stall_cnt (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
